demosaic_seq_ctrl: RTL and testbench

Frame sequencer for the neighbour-demosaic datapath. It resets the datapath per frame, gates the pixel stream into it, and injects the trailing zero-pixel flush rows the datapath needs to emit its last rows. It applies downstream backpressure by withholding the datapath clock-enable, then counts output pixels and reports frame completion and mismatch errors. It sits between the Bayer pixel source and the demosaic instance.

---
 rtl/demosaic_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_demosaic_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demosaic_seq_ctrl.sv
// Frame sequencer for the neighbour-demosaic datapath: per-frame datapath reset, source gating,
// trailing zero-pixel flush, backpressure and output accounting. Optional watchdog: DEMOSAIC_SEQ_TIMEOUT_EN.
module demosaic_seq_ctrl #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int KERNEL_SIZE = 7
`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        sink_ready,
    output logic [7:0]  dm_data,
    output logic        dm_valid,
    output logic        dm_reset,
    input  logic        dm_oValid,
    input  logic        dm_oDone,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [31:0] out_cnt
);
    localparam int BW        = (KERNEL_SIZE - 1) / 2;
    localparam int NPIX      = WIDTH * HEIGHT;
    localparam int FLUSH_PIX = WIDTH * (BW + 1);
    localparam int IN_W      = $clog2(NPIX + 1);
    localparam int FL_W      = $clog2(FLUSH_PIX + 1);

    localparam logic [IN_W-1:0] IN_LAST  = IN_W'(NPIX - 1);
    localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FLUSH_PIX - 1);
    localparam logic [31:0]     NPIX_32  = 32'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_DONE, S_ABORT, S_TOUT
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic [31:0]       out_cnt_q, out_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              dm_reset_q, dm_reset_d;
    logic              in_frame;

`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign in_frame = (state_q == S_CLEAR) || (state_q == S_STREAM) ||
                      (state_q == S_FLUSH) || (state_q == S_DRAIN);

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        out_cnt_d  = out_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        src_ready  = 1'b0;
        dm_valid   = 1'b0;
        dm_data    = 8'd0;
        frame_done = 1'b0;
        busy       = (state_q != S_IDLE);

        if (busy && dm_oValid) out_cnt_d = out_cnt_q + 32'd1;
        // Latch oDone from STREAM on so a done arriving during FLUSH is not lost.
        if (dm_oDone && (state_q == S_STREAM || state_q == S_FLUSH || state_q == S_DRAIN))
            done_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_CLEAR;
                    in_cnt_d  = '0;
                    fl_cnt_d  = '0;
                    out_cnt_d = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_CLEAR: state_d = S_STREAM;
            S_STREAM: begin
                src_ready = sink_ready;
                dm_valid  = src_valid & sink_ready;
                dm_data   = src_data;
                if (dm_valid) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IN_LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                dm_valid = sink_ready;
                if (dm_valid) begin
                    fl_cnt_d = fl_cnt_q + 1'b1;
                    if (fl_cnt_q == FL_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Judge the count on entry to DONE so err is valid alongside frame_done.
                if (done_q || dm_oDone) begin
                    state_d = S_DONE;
                    err_d   = err_q | (out_cnt_d != NPIX_32);
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_ABORT: state_d = S_IDLE;
            S_TOUT: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
        wd_d = wd_q;
        if (!in_frame || dm_valid || dm_oValid) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            wd_d    = '0;
            state_d = S_TOUT;
            err_d   = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
`endif

        if (abort && in_frame) state_d = S_ABORT;

        dm_reset_d = (state_d == S_CLEAR) || (state_d == S_ABORT) || (state_d == S_TOUT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_cnt_q   <= '0;
            fl_cnt_q   <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dm_reset_q <= 1'b1;
`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            out_cnt_q  <= out_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dm_reset_q <= dm_reset_d;
`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign dm_reset = dm_reset_q;
    assign err      = err_q;
    assign out_cnt  = out_cnt_q;
endmodule

// File: tb/tb_demosaic_seq_ctrl.sv
// Directed bench for demosaic_seq_ctrl with a small datapath model (WIDTH=8, HEIGHT=4, KERNEL_SIZE=7).
module tb_demosaic_seq_ctrl;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int K     = 7;
    localparam int BW    = (K - 1) / 2;
    localparam int FLUSH = W * (BW + 1);
    localparam int NPIX  = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [7:0]  src_data = 8'd0;
    logic        src_valid = 1'b0, sink_ready = 1'b1;
    logic        src_ready, dm_valid, dm_reset, busy, frame_done, err;
    logic [7:0]  dm_data;
    logic        dm_oValid, dm_oDone;
    logic [31:0] out_cnt;

    int total = 0;
    int bad = 0;

    // Stimulus controls, written only by the main initial block.
    logic src_en = 1'b1, sink_toggle = 1'b0, drop_one = 1'b0;
    int   stall_left = 0;
    int   stall_at = 12;

    always #5 clk = ~clk;

    demosaic_seq_ctrl #(
        .WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K)
`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .sink_ready(sink_ready), .dm_data(dm_data), .dm_valid(dm_valid),
        .dm_reset(dm_reset), .dm_oValid(dm_oValid), .dm_oDone(dm_oDone),
        .busy(busy), .frame_done(frame_done), .err(err), .out_cnt(out_cnt)
    );

    // Datapath model: one output per input beat once FLUSH beats have gone in; done with the last beat.
    int m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0; dm_oValid <= 1'b0; dm_oDone <= 1'b0;
        end else if (dm_reset) begin
            m_cnt <= 0; dm_oValid <= 1'b0; dm_oDone <= 1'b0;
        end else if (dm_valid) begin
            m_cnt     <= m_cnt + 1;
            dm_oValid <= (m_cnt >= FLUSH) && !(drop_one && m_cnt == FLUSH);
            dm_oDone  <= (m_cnt == NPIX + FLUSH - 1);
        end else begin
            dm_oValid <= 1'b0; dm_oDone <= 1'b0;
        end
    end

    // Monitor: beat counts, reset pulses, frame_done pulses and protocol violations.
    int vbeats = 0, rst_cyc = 0, fd_cnt = 0, viol = 0, data_err = 0, fb = 0, fsrc = 0;
    logic err_at_fd = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            if (dm_reset) begin
                rst_cyc <= rst_cyc + 1; fb <= 0; fsrc <= 0;
            end else begin
                if (dm_valid) begin
                    vbeats <= vbeats + 1;
                    fb     <= fb + 1;
                    if (dm_data !== ((fb < NPIX) ? 8'(fb + 1) : 8'd0)) data_err <= data_err + 1;
                    if (!sink_ready || (fb < NPIX && !src_valid)) viol <= viol + 1;
                end
                if (src_valid && src_ready) fsrc <= fsrc + 1;
            end
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1; err_at_fd <= err;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        sink_ready = sink_toggle ? ~sink_ready : 1'b1;
        if (stall_left > 0 && fsrc == stall_at) begin
            src_valid = 1'b0;
            stall_left--;
        end else begin
            src_valid = src_en;
        end
        src_data = 8'(fsrc + 1);
    endtask

    task automatic wait_done(input int budget, output int n);
        int base;
        base = fd_cnt;
        n = 0;
        while (fd_cnt == base && n < budget) begin
            tick();
            n++;
        end
        check("fd_seen", 32'(fd_cnt != base), 32'd1);
    endtask

    // Run one full frame and check beats, reset pulses, frame_done count, out_cnt and err.
    task automatic run_frame(input string tag, input int exp_out, input logic exp_err);
        int b_v, b_r, b_f, b_d, b_x, n;
        b_v = vbeats; b_r = rst_cyc; b_f = fd_cnt; b_d = data_err; b_x = viol;
        tick(); start = 1'b1; tick();
        check({tag, "_clear_rst"}, 32'(dm_reset), 32'd1);
        check({tag, "_clear_err"}, 32'(err), 32'd0);
        wait_done(600, n);
        repeat (3) tick();
        check({tag, "_beats"}, 32'(vbeats - b_v), 32'(NPIX + FLUSH));
        check({tag, "_rst_pulses"}, 32'(rst_cyc - b_r), 32'd1);
        check({tag, "_fd_pulses"}, 32'(fd_cnt - b_f), 32'd1);
        check({tag, "_out_cnt"}, out_cnt, 32'(exp_out));
        check({tag, "_err_at_fd"}, 32'(err_at_fd), 32'(exp_err));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(data_err - b_d), 32'd0);
        check({tag, "_viol"}, 32'(viol - b_x), 32'd0);
    endtask

    initial begin
        int n, b_r, b_f;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dm_reset", 32'(dm_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dm_valid", 32'(dm_valid), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_cnt", out_cnt, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_dm_reset", 32'(dm_reset), 32'd0);

        // 1: basic frame
        run_frame("basic", NPIX, 1'b0);

        // 2: sink toggling every cycle
        sink_toggle = 1'b1;
        run_frame("toggle", NPIX, 1'b0);
        sink_toggle = 1'b0;

        // 3: source stall of 5 cycles mid-row
        stall_left = 5;
        run_frame("stall", NPIX, 1'b0);
        check("stall_used", 32'(stall_left), 32'd0);

        // 4: abort after 10 source beats, then a clean frame
        b_r = rst_cyc; b_f = fd_cnt;
        tick(); start = 1'b1; tick();
        n = 0;
        while (fsrc < 10 && n < 100) begin tick(); n++; end
        check("abort_reach", 32'(fsrc >= 10), 32'd1);
        abort = 1'b1;
        repeat (4) tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_fd", 32'(fd_cnt - b_f), 32'd0);
        check("abort_rst_pulses", 32'(rst_cyc - b_r), 32'd2);
        check("abort_err", 32'(err), 32'd0);
        run_frame("post_abort", NPIX, 1'b0);

        // Start and abort together in IDLE: abort wins
        tick(); start = 1'b1; abort = 1'b1; tick(); tick();
        check("start_abort_idle", 32'(busy), 32'd0);

        // 5: datapath emits one output short -> err; next start clears it
        drop_one = 1'b1;
        run_frame("short", NPIX - 1, 1'b1);
        drop_one = 1'b0;
        run_frame("recover", NPIX, 1'b0);

        // 6: source silent after start
        src_en = 1'b0;
        b_f = fd_cnt;
        tick(); start = 1'b1; tick();
`ifdef DEMOSAIC_SEQ_TIMEOUT_EN
        wait_done(60, n);
        check("wd_cycles_in_range", 32'(n >= 16 && n <= 18), 32'd1);
        check("wd_err_at_fd", 32'(err_at_fd), 32'd1);
        repeat (3) tick();
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_err", 32'(err), 32'd1);
`else
        repeat (200) tick();
        check("nowd_busy", 32'(busy), 32'd1);
        check("nowd_no_fd", 32'(fd_cnt - b_f), 32'd0);
        check("nowd_dm_valid", 32'(dm_valid), 32'd0);
        abort = 1'b1;
        repeat (4) tick();
        check("nowd_abort_busy", 32'(busy), 32'd0);
`endif
        src_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait was mis-bounded.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
